if_fetch: RTL
=============

# if_fetch

Instruction-fetch initiator for the IF stage. Owns the program counter, issues word addresses to the synchronous-read instruction memory (`instr_mem`, one-cycle read latency, read on every clock), pairs each returned word with its PC, and delivers (pc, instr) beats to decode over a valid/ready handshake. A 2-entry output buffer absorbs decode stalls without losing in-flight reads. A redirect port accepts PC changes from branch/jump resolution.

## Interface
- `RESET_PC`, 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `imem_addr` out 32: byte address to `instr_mem`; always word-aligned.
- `imem_instr` in 32: memory data; in the cycle after an edge, holds the word for the `imem_addr` sampled at that edge.
- `redirect_valid` in 1: load new PC this cycle; flush all pending fetches.
- `redirect_pc` in 32: redirect target; bits [1:0] ignored (forced 0).
- `out_valid` out 1: a fetched beat is presented.
- `out_ready` in 1: decode accepts the beat.
- `out_pc` out 32: PC of the presented beat.
- `out_instr` out 32: instruction of the presented beat.

## Operation
- State: `fetch_pc` (drives `imem_addr` directly), `infl_v`/`infl_pc` (request issued at previous edge), 2-entry FIFO of {pc, instr}, occupancy `occ` 0..2.
- Pop = `out_valid & out_ready`. Head of FIFO drives `out_pc`/`out_instr`; `out_valid = (occ != 0)`.
- Issue rule at each edge: issue iff `occ + infl_v - pop <= 1`. On issue: `infl_v<=1`, `infl_pc<=fetch_pc`, `fetch_pc<=fetch_pc+4`. Otherwise `infl_v<=0`, `fetch_pc` holds.
- Capture: if `infl_v`, push {`infl_pc`, `imem_instr`} at the edge. The issue rule guarantees push never overflows; push and pop in the same cycle are simultaneous.
- PC arithmetic is 32-bit modulo: 0xFFFF_FFFC + 4 = 0x0000_0000.
- Redirect (edge with `redirect_valid=1`): `fetch_pc<=redirect_pc & ~3`, `occ<=0`, `infl_v<=0`. This edge does not issue or capture. A pop in the same cycle completes; decode keeps that beat.
- Priority: `rst` > `redirect_valid` > normal issue/capture.
- Reset (asynchronous, immediate): `fetch_pc=RESET_PC`, `occ=0`, `infl_v=0`, `infl_pc=0`, `out_valid=0`, `out_pc=0`, `out_instr=0`, FIFO contents 0. Reset mid-stream discards all pending beats.
- `out_pc`/`out_instr` stay stable while `out_valid=1` and `out_ready=0`.

## Timing
- Edge E0 is the first edge with `rst=0`. `RESET_PC` issues at E0. `imem_instr` is valid after E0, the word is pushed at E1, and `out_valid=1` after E1. First-beat latency is 2 edges.
- Redirect latency: redirect at edge R. `out_valid=0` after R. The target is issued at R+1 and presented after R+2.
- Steady state with `out_ready=1`: one beat per cycle, `occ=1`, `infl_v=1`, PCs strictly +4 with no gaps or duplicates.
- Stall with `out_ready=0`: at most 2 beats buffered plus 0 in flight. `imem_addr` freezes once `occ+infl_v=2`.
- Resume after stall: beats continue with no bubble while the FIFO is non-empty. Sustained rate returns to 1 beat/cycle.

## Test plan
- Reset/stream: memory words 0,1,2 = 00400093, 00800113, 002081b3; `out_ready=1`. Expect `out_valid` rising after E1, then beats (0x0,00400093), (0x4,00800113), (0x8,002081b3) on consecutive cycles.
- Backpressure: drop `out_ready` for 5 cycles after the first beat is accepted. Expect (0x4,00800113) held stable and `imem_addr` frozen at 0xC. After release, expect 0x4, 0x8, 0xC back-to-back with no duplicate or skip.
- Redirect: `redirect_valid=1`, `redirect_pc=0x43` while streaming. Expect `out_valid=0` for 2 cycles, then first beat pc 0x40 with `mem[16]`, and no old-stream PC after the redirect edge.
- Redirect with simultaneous pop and full FIFO: the popped beat is counted once. Expect no further old beats, then 0x40 after 2 edges.
- Wrap: redirect to 0xFFFF_FFFC. Expect beats pc 0xFFFF_FFFC then 0x0000_0000.
- Async reset mid-stream (asserted between edges): `out_valid`, `out_pc`, `out_instr` go to 0 immediately and `imem_addr=RESET_PC`. After release, the stream restarts at `RESET_PC` with 2-edge latency.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch initiator for the IF stage.
// Owns the program counter, issues word addresses to a synchronous-read
// instruction memory (one-cycle latency), pairs each returned word with the
// PC that produced it, and hands (pc, instr) beats to decode over a
// valid/ready handshake. A 2-entry buffer holds words already in flight when
// decode stalls, so no read is ever lost or repeated.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // Instruction memory request/response
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  // Redirect from branch/jump resolution
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  // Beats to decode
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Next PC to be issued; drives the memory address directly.
  logic [31:0] r_fetch_pc;
  // Request issued at the previous edge; its data is on imem_instr now.
  logic        r_infl_v;
  logic [31:0] r_infl_pc;
  // Two-entry circular buffer of fetched beats.
  logic [31:0] r_fifo_pc    [2];
  logic [31:0] r_fifo_instr [2];
  logic        r_head;
  logic [1:0]  r_occ;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic [2:0]  w_level;
  logic        w_wr_idx;
  logic [1:0]  w_occ_nxt;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_fetch_pc_inc;

  assign out_valid = (r_occ != 2'd0);
  assign out_pc    = r_fifo_pc[r_head];
  assign out_instr = r_fifo_instr[r_head];
  assign imem_addr = r_fetch_pc;

  assign w_pop  = out_valid & out_ready;
  assign w_push = r_infl_v;

  // Slots that will be committed after this edge if nothing new is issued.
  // Pop only happens with occ >= 1, so this never underflows.
  assign w_level = {1'b0, r_occ} + {2'b00, r_infl_v} - {2'b00, w_pop};

  // Only issue if the returning word is guaranteed a free slot next edge.
  assign w_issue = (w_level <= 3'd1);

  // Tail slot: head when empty, the other slot when one entry is held.
  // A push never coincides with occ == 2, so that case needs no slot.
  assign w_wr_idx = r_head ^ r_occ[0];

  assign w_redirect_pc  = {redirect_pc[31:2], 2'b00};
  assign w_fetch_pc_inc = r_fetch_pc + 32'd4;

  // Next occupancy for the normal (non-redirect) path.
  always_comb begin
    w_occ_nxt = r_occ;
    unique case ({w_push, w_pop})
      2'b10:   w_occ_nxt = r_occ + 2'd1;
      2'b01:   w_occ_nxt = r_occ - 2'd1;
      default: w_occ_nxt = r_occ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request side: PC and in-flight tracking
  // ---------------------------------------------------------------------------
  // Advance the PC on issue; a redirect reloads it and drops the in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_infl_v   <= 1'b0;
      r_infl_pc  <= 32'd0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_pc;
      r_infl_v   <= 1'b0;
    end else if (w_issue) begin
      r_fetch_pc <= w_fetch_pc_inc;
      r_infl_v   <= 1'b1;
      r_infl_pc  <= r_fetch_pc;
    end else begin
      r_infl_v   <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Response side: beat buffer
  // ---------------------------------------------------------------------------
  // Capture the returning word and retire accepted beats; redirect empties it.
  // A beat popped on the redirect edge is still delivered to decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo_pc[0]    <= 32'd0;
      r_fifo_pc[1]    <= 32'd0;
      r_fifo_instr[0] <= 32'd0;
      r_fifo_instr[1] <= 32'd0;
      r_head          <= 1'b0;
      r_occ           <= 2'd0;
    end else if (redirect_valid) begin
      r_occ <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_pc[w_wr_idx]    <= r_infl_pc;
        r_fifo_instr[w_wr_idx] <= imem_instr;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_occ <= w_occ_nxt;
    end
  end

endmodule
